// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared types and constants for the DAC SPI driver
// Contents: FSM state enum, default frame length and default config nibble.
package dac_spi_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CS_HOLD, LDAC, DONE} state_e;
    localparam int FRAME_BITS = 16;
    localparam logic [3:0] CFG_DEFAULT = 4'b0011;
endpackage

// File: rtl/dac_spi_driver_sclk_divider.sv
// sclk_divider: CLK_DIV-cycle half-period timer for the SPI clock
// Ports: clk, rst (sync, active high); clr_i holds the counter and phase at zero;
//        half_tick_o marks the last cycle of each half period; phase_o toggles after every half_tick_o.
module sclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic half_tick_o,
    output logic phase_o
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic phase_q, phase_d;
    assign half_tick_o = cnt_q == CW'(CLK_DIV - 1);
    assign phase_o = phase_q;
    always_comb begin
        cnt_d = (clr_i || half_tick_o) ? '0 : cnt_q + 1'b1;
        phase_d = clr_i ? 1'b0 : phase_q ^ half_tick_o;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: sends changed DAC codes as {CFG_BITS, code} SPI frames (mode 0, MSB first), then pulses LDAC
// Ports: clk, rst (sync, active high); dac_code/no_order select the target code;
//        spi_sclk/spi_mosi/spi_cs_n drive the DAC, dac_ldac_n latches it;
//        busy (not IDLE), frame_done (one-cycle end-of-frame pulse), last_code (last code written).
// Option: define DAC_SLEW_EN to limit each frame's code change to MAX_STEP.
module dac_spi_driver
    import dac_spi_pkg::*;
#(
    parameter int DAC_WIDTH = 12,
    parameter int CLK_DIV = 4,
    parameter logic [3:0] CFG_BITS = CFG_DEFAULT
`ifdef DAC_SLEW_EN
    ,
    parameter int MAX_STEP = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DAC_WIDTH-1:0] dac_code,
    input  logic                 no_order,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    output logic                 spi_cs_n,
    output logic                 dac_ldac_n,
    output logic                 busy,
    output logic                 frame_done,
    output logic [DAC_WIDTH-1:0] last_code
);
    localparam int FW = 4 + DAC_WIDTH;
    localparam int BW = $clog2(FW);
    state_e state_q, state_d;
    logic [FW-1:0] sh_q, sh_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DAC_WIDTH-1:0] frame_code_q, frame_code_d, last_code_q, last_code_d;
    logic init_q, init_d;
    logic [DAC_WIDTH-1:0] target, send_code;
    logic tick, phase, sclk_hi;
    sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (state_q == IDLE),
        .half_tick_o (tick),
        .phase_o     (phase)
    );
    // phase is 0 through LOAD, so each SHIFT bit starts on phase 1 (SCLK low) and ends on phase 0 (SCLK high)
    assign sclk_hi = !phase;
    assign target = no_order ? '0 : dac_code;
`ifdef DAC_SLEW_EN
    logic [DAC_WIDTH:0] diff, step;
    logic up;
    assign up = target > last_code_q;
    assign diff = up ? {1'b0, target} - {1'b0, last_code_q} : {1'b0, last_code_q} - {1'b0, target};
    assign step = diff > (DAC_WIDTH + 1)'(MAX_STEP) ? (DAC_WIDTH + 1)'(MAX_STEP) : diff;
    assign send_code = up ? DAC_WIDTH'({1'b0, last_code_q} + step) : DAC_WIDTH'({1'b0, last_code_q} - step);
`else
    assign send_code = target;
`endif
    always_comb begin
        state_d = state_q;
        sh_d = sh_q;
        bit_d = bit_q;
        frame_code_d = frame_code_q;
        last_code_d = last_code_q;
        init_d = init_q;
        case (state_q)
            IDLE: if (init_q || target != last_code_q) begin
                frame_code_d = send_code;
                sh_d = {CFG_BITS, send_code};
                bit_d = BW'(FW - 1);
                state_d = LOAD;
            end
            LOAD: state_d = tick ? SHIFT : LOAD;
            // SCLK falls on this tick: advance MOSI, or finish after bit 0
            SHIFT: if (tick && sclk_hi) begin
                if (bit_q == '0) state_d = CS_HOLD;
                else begin
                    bit_d = bit_q - 1'b1;
                    sh_d = {sh_q[FW-2:0], 1'b0};
                end
            end
            CS_HOLD: state_d = tick ? LDAC : CS_HOLD;
            LDAC: state_d = tick ? DONE : LDAC;
            DONE: begin
                last_code_d = frame_code_q;
                init_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q <= '0;
            bit_q <= '0;
            frame_code_q <= '0;
            last_code_q <= '0;
            init_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sh_q <= sh_d;
            bit_q <= bit_d;
            frame_code_q <= frame_code_d;
            last_code_q <= last_code_d;
            init_q <= init_d;
        end
    end
    assign spi_cs_n = !(state_q == LOAD || state_q == SHIFT);
    assign spi_sclk = state_q == SHIFT && sclk_hi;
    assign spi_mosi = !spi_cs_n && sh_q[FW-1];
    assign dac_ldac_n = state_q != LDAC;
    assign busy = state_q != IDLE;
    assign frame_done = state_q == DONE;
    assign last_code = last_code_q;
endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: scoreboard bench for dac_spi_driver
module tb_dac_spi_driver;
    import dac_spi_pkg::*;
    localparam int DW = 12;
    localparam int CD = 4;
    localparam int LAT = 35 * CD + 1;
    logic clk = 1'b0, rst = 1'b1, no_order = 1'b0;
    logic [DW-1:0] dac_code = '0;
    logic spi_sclk, spi_mosi, spi_cs_n, dac_ldac_n, busy, frame_done;
    logic [DW-1:0] last_code;
    dac_spi_driver #(.DAC_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clk        (clk),
        .rst        (rst),
        .dac_code   (dac_code),
        .no_order   (no_order),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .dac_ldac_n (dac_ldac_n),
        .busy       (busy),
        .frame_done (frame_done),
        .last_code  (last_code)
    );
    always #5 clk = ~clk;
    int tests = 0, fails = 0, frames = 0, ldac_cycles = 0;
    logic [FRAME_BITS-1:0] exp_q[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic wait_frames(input int n, input string name);
        int t = 0;
        while (frames < n && t < 1000) begin
            @(posedge clk);
            t++;
        end
        chk(name, frames, n);
        repeat (3) @(posedge clk);
        #1;
    endtask
    task automatic wait_busy(input string name);
        int t = 0;
        while (!busy && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, {31'b0, busy}, 32'd1);
    endtask
    logic [FRAME_BITS-1:0] cap = '0, e = '0;
    int nbits = 0, lat = 0;
    logic p_sclk = 1'b0, p_cs = 1'b1, p_busy = 1'b0, chk_last = 1'b0;
    logic [DW-1:0] last_exp = '0;
    always @(negedge clk) begin
        if (chk_last) begin
            chk("last_code", last_code, last_exp);
            chk_last = 1'b0;
        end
        if (p_cs && !spi_cs_n) begin
            cap = '0;
            nbits = 0;
        end
        if (!p_sclk && spi_sclk) begin
            cap = {cap[FRAME_BITS-2:0], spi_mosi};
            nbits++;
        end
        lat = busy ? (p_busy ? lat + 1 : 1) : 0;
        if (!dac_ldac_n) ldac_cycles++;
        if (frame_done) begin
            frames++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got 0x%0h expected none", cap);
            end else begin
                e = exp_q.pop_front();
                chk("frame", cap, e);
                chk("frame_bits", nbits, FRAME_BITS);
                chk("latency", lat, LAT);
                last_exp = e[DW-1:0];
                chk_last = 1'b1;
            end
        end
        p_sclk = spi_sclk;
        p_cs = spi_cs_n;
        p_busy = busy;
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_ldac_n", dac_ldac_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_last_code", last_code, 0);
        exp_q.push_back(16'h3000);
        rst = 1'b0;
        wait_frames(1, "init_frame");
`ifdef DAC_SLEW_EN
        dac_code = 12'h0A0;
        exp_q.push_back(16'h3040);
        exp_q.push_back(16'h3080);
        exp_q.push_back(16'h30A0);
        wait_frames(4, "slew_frames");
        repeat (200) @(posedge clk);
        chk("slew_no_extra", frames, 4);
`else
        dac_code = 12'h0A0;
        exp_q.push_back(16'h30A0);
        wait_frames(2, "steady_frame");
        repeat (200) @(posedge clk);
        #1;
        chk("steady_no_extra", frames, 2);
        dac_code = 12'h123;
        exp_q.push_back(16'h3123);
        exp_q.push_back(16'h3789);
        wait_busy("busy_123");
        repeat (19) @(posedge clk);
        #1;
        dac_code = 12'h456;
        repeat (40) @(posedge clk);
        #1;
        dac_code = 12'h789;
        wait_frames(4, "newest_wins");
        dac_code = 12'h200;
        exp_q.push_back(16'h3200);
        wait_frames(5, "frame_200");
        no_order = 1'b1;
        exp_q.push_back(16'h3000);
        wait_frames(6, "no_order_frame");
        no_order = 1'b0;
        dac_code = 12'h0F0;
        wait_busy("busy_0f0");
        repeat (69) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_cs_n", spi_cs_n, 1);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_ldac_n", dac_ldac_n, 1);
        chk("abort_busy", busy, 0);
        chk("abort_frames", frames, 6);
        rst = 1'b0;
        exp_q.push_back(16'h30F0);
        wait_frames(7, "post_abort_init");
        repeat (200) @(posedge clk);
        #1;
        chk("final_no_extra", frames, 7);
`endif
        chk("ldac_cycles", ldac_cycles, frames * CD);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dac_spi_driver.md
Name: dac_spi_driver

Overview:
- Downstream of the ultrasonic order/DAC-control stage; consumes its 12-bit outputDAC code and no_order flag.
- Serialises each new code into a 16-bit SPI frame for an external 12-bit DAC, then pulses the DAC's LDAC latch.
- Sends a frame only when the target code differs from the last code written, plus one unconditional frame after reset.

Parameters:
- DAC_WIDTH, 12, code width; frame = 4 config bits + DAC_WIDTH bits, so the frame is 16 bits at the default.
- CLK_DIV, 4, clk cycles per SCLK half-period; minimum 1.
- CFG_BITS, 4'b0011, config nibble sent as frame bits [15:12].
- MAX_STEP, 64, maximum code change per frame; used only with DAC_SLEW_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- dac_code  input  DAC_WIDTH  requested code, driven by outputDAC upstream.
- no_order  input  1  when 1, target code is forced to 0.
- spi_sclk  output  1  SPI clock, mode 0, idles low.
- spi_mosi  output  1  serial data, MSB first.
- spi_cs_n  output  1  chip select, active low.
- dac_ldac_n  output  1  DAC latch strobe, active low.
- busy  output  1  high whenever the state is not IDLE.
- frame_done  output  1  one-cycle pulse at the end of each frame.
- last_code  output  DAC_WIDTH  code of the last completed frame.

Behaviour:
- Reset (clk edge with rst=1) returns all outputs to idle: spi_sclk=0, spi_mosi=0, spi_cs_n=1, dac_ldac_n=1, busy=0, frame_done=0, last_code=0, init_pending=1, state=IDLE.
- Reset during a frame aborts it immediately. No partial latch: LDAC is never pulsed for an aborted frame.
- Target code: target = no_order ? 0 : dac_code, evaluated combinationally.
- IDLE: if init_pending or target != last_code, capture the send code into shadow register frame_code and go to LOAD. Otherwise stay in IDLE.
- LOAD (CLK_DIV cycles):
  - spi_cs_n=0, spi_sclk=0.
  - Shift register loaded with {CFG_BITS, frame_code}; spi_mosi = bit 15.
- SHIFT (16 bits, 2*CLK_DIV cycles each):
  - spi_sclk low for the first CLK_DIV cycles of a bit, high for the second CLK_DIV cycles.
  - spi_mosi changes only on the cycle that sclk falls, so it is stable across the rising edge.
  - After bit 0's high phase: spi_sclk=0, go to CS_HOLD.
- CS_HOLD (CLK_DIV cycles): spi_cs_n=1, spi_mosi=0.
- LDAC (CLK_DIV cycles): dac_ldac_n=0.
- DONE (1 cycle):
  - dac_ldac_n=1, frame_done=1.
  - last_code = frame_code, init_pending=0.
  - Return to IDLE.
- Frame latency from leaving IDLE to the frame_done cycle: 35*CLK_DIV + 1 cycles, which is 141 cycles at default.
- busy is 1 in every state except IDLE.
- Input changes during a frame are ignored; the frame in flight is not altered. When the frame returns to IDLE, the new target is compared against last_code next cycle, so the newest value always wins and intermediate values may be skipped.
- Back-to-back frames: IDLE lasts at least 1 cycle between frames.
- Target equal to last_code after a frame: no frame is sent.
- no_order toggling mid-frame has no effect until IDLE.
- Arithmetic: pure unsigned DAC_WIDTH; no wrap handling is needed because codes pass through unchanged without slew.

Optional Feature:
- Macro: DAC_SLEW_EN.
- Defined: in IDLE, frame_code = last_code ± min(|target − last_code|, MAX_STEP), computed in DAC_WIDTH+1 bits with no wrap. Frames repeat until last_code == target; the target may change between steps.
- Not defined: frame_code = target directly. MAX_STEP is unused.

Decomposition:
- Package dac_spi_pkg holds:
  - state enum {IDLE, LOAD, SHIFT, CS_HOLD, LDAC, DONE};
  - FRAME_BITS = 16;
  - the default CFG_BITS localparam.
- Natural sub-module: sclk_divider, a CLK_DIV cycle counter producing half_tick and a phase bit, reset by the FSM on LOAD entry.

Test Plan:
- Reset release with dac_code=0, no_order=0 → one init frame 0x3000; frame_done at cycle 141; last_code=0.
- dac_code=0x0A0 steady → exactly one frame; MOSI sampled on 16 SCLK rising edges = 0x30A0; then no further frames.
- dac_code=0x123, then 0x456 at cycle 20 of the frame, then 0x789 at cycle 60:
  - the first frame still sends 0x3123;
  - the next frame sends 0x3789;
  - 0x456 is never sent.
- last_code=0x200, no_order raised → next frame 0x3000, last_code=0.
- rst asserted at cycle 70 of a frame → the next cycle shows cs_n=1, sclk=0, ldac_n=1, busy=0, no LDAC pulse, and an init frame follows after release.
- DAC_SLEW_EN defined, MAX_STEP=64, last_code=0, dac_code=0x0A0 → frames 0x3040, 0x3080, 0x30A0, then idle.
